// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// BOOT/RUN/HALT control FSM. imem is read combinationally from the current PC.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src_en,
  input  logic [31:0] pc_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_cnt,
  output logic [31:0] out
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_plus4;
  ifid_t       ifid, ifid_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] cnt_inc;
  logic        is_halt_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
      ifid  <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      cnt   <= 16'h0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ifid  <= ifid_n;
      cnt   <= cnt_n;
    end
  end

  assign pc_plus4     = pc + 32'd4;
  assign cnt_inc      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign is_halt_word = (imem_rdata[31:26] == HALT_OPCODE);

  // Redirect beats stall, stall beats normal advance; flush only ever turns
  // the incoming slot into a bubble and never changes what happens to the PC.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ifid_n  = ifid;
    cnt_n   = cnt;
    unique case (state)
      S_BOOT: begin
        ifid_n.instr = NOP_INSTR;
        ifid_n.valid = 1'b0;
        state_n      = S_RUN;
      end
      S_RUN: begin
        if (pc_src_en) begin
          pc_n         = pc_target & 32'hFFFF_FFFC;
          ifid_n.instr = NOP_INSTR;
          ifid_n.valid = 1'b0;
        end else if (stall) begin
          if (flush) begin
            ifid_n.instr = NOP_INSTR;
            ifid_n.valid = 1'b0;
          end
        end else if (flush) begin
          pc_n         = pc_plus4;
          ifid_n.instr = NOP_INSTR;
          ifid_n.valid = 1'b0;
        end else begin
          ifid_n = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
          cnt_n  = cnt_inc;
          // The halt word itself is delivered; the PC parks on its address.
          if (is_halt_word) state_n = S_HALT;
          else              pc_n    = pc_plus4;
        end
      end
      S_HALT: begin
        ifid_n.instr = NOP_INSTR;
        ifid_n.valid = 1'b0;
        if (pc_src_en) begin
          pc_n    = pc_target & 32'hFFFF_FFFC;
          state_n = S_RUN;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end

  assign imem_addr   = pc;
  assign out         = pc;
  assign if_id_instr = ifid.instr;
  assign if_id_pc4   = ifid.pc4;
  assign if_id_valid = ifid.valid;
  assign halted      = (state == S_HALT);
  assign fetch_cnt   = cnt;

endmodule

// File: tb/tb_if_stage.sv
// Fetch-stage bench: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model, then counter saturation.
module tb_if_stage;
  logic        clk;
  logic        reset, stall, flush, pc_src_en;
  logic [31:0] pc_target, imem_addr, imem_rdata, if_id_instr, if_id_pc4, out;
  logic        if_id_valid, halted;
  logic [15:0] fetch_cnt;

  logic [31:0] mem [0:63];
  int n_tests = 0;
  int n_fail  = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pc_src_en(pc_src_en), .pc_target(pc_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_cnt(fetch_cnt), .out(out)
  );

  assign imem_rdata = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = boot cycle, 1 = fetching, 2 = halted
  bit          m_known = 1'b0;
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_pc4, w;
  logic        m_valid;
  int          m_cnt;

  always @(posedge clk) begin
    if (!reset) begin
      m_known = 1'b1; m_phase = 0; m_pc = 32'h0;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 0;
    end else if (m_known) begin
      if (m_phase == 0) begin
        m_instr = 32'h0; m_valid = 1'b0; m_phase = 1;
      end else if (pc_src_en) begin
        m_pc = {pc_target[31:2], 2'b00}; m_instr = 32'h0; m_valid = 1'b0; m_phase = 1;
      end else if (m_phase == 2) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else if (stall) begin
        if (flush) begin m_instr = 32'h0; m_valid = 1'b0; end
      end else begin
        w = mem[m_pc[7:2]];
        if (flush) begin
          m_instr = 32'h0; m_valid = 1'b0; m_pc = m_pc + 4;
        end else begin
          m_instr = w; m_pc4 = m_pc + 4; m_valid = 1'b1;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          if (w[31:26] == 6'h3F) m_phase = 2;
          else m_pc = m_pc + 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("out", out, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
      chk("halted", {31'h0, halted}, {31'h0, m_phase == 2});
      chk("fetch_cnt", {16'h0, fetch_cnt}, m_cnt);
      if (m_valid) begin
        chk("instr", if_id_instr, m_instr);
        chk("pc4", if_id_pc4, m_pc4);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] v;
    v = $urandom;
    if (v[31:26] == 6'h3F) v[31:26] = 6'h00;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = rnd_word();
    mem[0] = 32'h2008_0005; mem[3] = 32'h0123_4567; mem[4] = 32'h89AB_CDEF;
    mem[6] = 32'hFC00_0000; mem[16] = 32'h1111_2222; mem[63] = 32'h3333_4444;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src_en = 1'b0; pc_target = 32'h0;

    cyc(2);
    chk("rst_out", out, 32'h0); chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_cnt", {16'h0, fetch_cnt}, 32'h0);
    reset = 1'b1; cyc();
    chk("boot_valid", {31'h0, if_id_valid}, 32'h0); chk("boot_out", out, 32'h0);
    cyc();
    chk("f1_out", out, 32'h4); chk("f1_instr", if_id_instr, 32'h2008_0005);
    chk("f1_pc4", if_id_pc4, 32'h4); chk("f1_cnt", {16'h0, fetch_cnt}, 32'h1);
    cyc(3);
    chk("pre_stall_out", out, 32'h10);
    stall = 1'b1; cyc(3);
    chk("stall_out", out, 32'h10); chk("stall_instr", if_id_instr, 32'h0123_4567);
    chk("stall_cnt", {16'h0, fetch_cnt}, 32'h4);
    stall = 1'b0; cyc();
    chk("unstall_out", out, 32'h14); chk("unstall_instr", if_id_instr, 32'h89AB_CDEF);
    cyc(2);
    chk("halt_instr", if_id_instr, 32'hFC00_0000); chk("halt_valid", {31'h0, if_id_valid}, 32'h1);
    chk("halt_out", out, 32'h18); chk("halt_flag", {31'h0, halted}, 32'h1);
    cyc();
    chk("halt_bubble", {31'h0, if_id_valid}, 32'h0); chk("halt_hold", out, 32'h18);
    pc_src_en = 1'b1; pc_target = 32'h0; cyc();
    chk("unhalt_flag", {31'h0, halted}, 32'h0); chk("unhalt_out", out, 32'h0);
    pc_target = 32'h20; cyc();
    chk("jmp20", out, 32'h20);
    pc_target = 32'h43; stall = 1'b1; cyc();
    chk("redir_out", out, 32'h40); chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
    pc_src_en = 1'b0; stall = 1'b0; cyc();
    chk("f40_out", out, 32'h44); chk("f40_instr", if_id_instr, 32'h1111_2222);
    chk("f40_pc4", if_id_pc4, 32'h44);
    pc_src_en = 1'b1; pc_target = 32'hFFFF_FFFE; cyc();
    chk("top_out", out, 32'hFFFF_FFFC);
    pc_src_en = 1'b0; cyc();
    chk("wrap_out", out, 32'h0); chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h3333_4444);
    pc_src_en = 1'b1; pc_target = 32'h30; cyc();
    chk("j30", out, 32'h30);
    pc_src_en = 1'b0; stall = 1'b1; reset = 1'b0; cyc();
    chk("rst2_out", out, 32'h0); chk("rst2_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst2_cnt", {16'h0, fetch_cnt}, 32'h0);
    reset = 1'b1; stall = 1'b0; cyc();
    flush = 1'b1; cyc();
    chk("flush_out", out, 32'h4); chk("flush_valid", {31'h0, if_id_valid}, 32'h0);
    chk("flush_cnt", {16'h0, fetch_cnt}, 32'h0);
    flush = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(99) != 0);
      stall     = ($urandom_range(99) < 20);
      flush     = ($urandom_range(99) < 15);
      pc_src_en = ($urandom_range(99) < 10);
      pc_target = $urandom;
      cyc();
    end

    mem[6] = 32'h0000_1234;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src_en = 1'b0; cyc(2);
    reset = 1'b1; cyc(65540);
    chk("sat_cnt", {16'h0, fetch_cnt}, 32'hFFFF);
    cyc(3);
    chk("sat_hold", {16'h0, fetch_cnt}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
